// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling and a
// valid/ack holding register with framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned clk_freq  = 50000000,
    parameter int unsigned baud_rate = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_line,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int unsigned clks_per_bit = clk_freq / baud_rate;
    localparam int unsigned half_bit     = clks_per_bit / 2;
    // Counters restart at 0 on the cycle after a transition, so compare against N-1.
    localparam logic [15:0] bit_last_c   = 16'(clks_per_bit - 1);
    localparam logic [15:0] half_last_c  = 16'(half_bit - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } state_t;

    state_t      state_r;
    logic        sync1_r;
    logic        rx_s;
    logic [15:0] clk_count_r;
    logic [2:0]  bit_index_r;
    logic [7:0]  shift_r;

    // Two-flop synchroniser on the asynchronous serial pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_r <= rx_line;
            rx_s    <= sync1_r;
        end
    end

    // Frame FSM with bit timing, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            clk_count_r  <= 16'd0;
            bit_index_r  <= 3'd0;
            shift_r      <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_busy      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            if (rx_ack) begin
                rx_valid <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_r     <= START;
                        clk_count_r <= 16'd0;
                        rx_busy     <= 1'b1;
                    end
                end
                START: begin
                    if (clk_count_r == half_last_c) begin
                        clk_count_r <= 16'd0;
                        bit_index_r <= 3'd0;
                        if (!rx_s) begin
                            state_r <= DATA;
                        end else begin
                            state_r <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        clk_count_r <= clk_count_r + 16'd1;
                    end
                end
                DATA: begin
                    if (clk_count_r == bit_last_c) begin
                        clk_count_r <= 16'd0;
                        shift_r     <= {rx_s, shift_r[7:1]};
                        if (bit_index_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_index_r <= bit_index_r + 3'd1;
                        end
                    end else begin
                        clk_count_r <= clk_count_r + 16'd1;
                    end
                end
                STOP: begin
                    if (clk_count_r == bit_last_c) begin
                        clk_count_r <= 16'd0;
                        if (rx_s) begin
                            // A same-cycle ack consumes the old byte, so no overrun.
                            rx_data    <= shift_r;
                            rx_valid   <= 1'b1;
                            rx_overrun <= rx_valid & ~rx_ack;
                            state_r    <= IDLE;
                            rx_busy    <= 1'b0;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state_r      <= BREAK_WAIT;
                        end
                    end else begin
                        clk_count_r <= clk_count_r + 16'd1;
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state_r <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx (10 clocks per bit) against a
// frame-level model of received bytes, valid flag and error pulse counts.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_line;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    logic prev_valid = 1'b0;

    // Model of the consumer-visible state.
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_ferr;
    int         exp_ovr;
    int         c0;

    uart_rx #(.clk_freq(1000000), .baud_rate(100000)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_line      (rx_line),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters (cycles high) and rx_valid rise timestamp.
    always @(negedge clk) begin
        n_ferr     <= n_ferr + int'(rx_frame_err);
        n_ovr      <= n_ovr + int'(rx_overrun);
        prev_valid <= rx_valid;
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one frame starting at a negedge; optional one-cycle ack and reset pulse at wait index.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int ack_at, input int rst_at);
        logic [9:0] fr;
        int k;
        fr = {stop_bit, b, 1'b0};
        c0 = cyc;
        k  = 0;
        for (int i = 0; i < 10; i++) begin
            rx_line = fr[i];
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                k++;
                rx_ack = (k == ack_at);
                if (k == rst_at) begin
                    reset = 1'b0;
                    #1;
                    check_eq("rst_data",  32'(rx_data), 32'h00);
                    check_eq("rst_valid", 32'(rx_valid), 32'h0);
                    check_eq("rst_busy",  32'(rx_busy), 32'h0);
                    check_eq("rst_ferr",  32'(rx_frame_err), 32'h0);
                    check_eq("rst_ovr",   32'(rx_overrun), 32'h0);
                end
                if (rst_at > 0 && k == rst_at + 3) reset = 1'b1;
            end
        end
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_good(input logic [7:0] b);
        if (exp_valid) exp_ovr++;
        exp_valid = 1'b1;
        exp_data  = b;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_data"},  32'(rx_data), 32'(exp_data));
        check_eq({tag, "_valid"}, 32'(rx_valid), 32'(exp_valid));
        check_eq({tag, "_ferr"},  32'(n_ferr), 32'(exp_ferr));
        check_eq({tag, "_ovr"},   32'(n_ovr), 32'(exp_ovr));
    endtask

    initial begin
        logic [7:0] b;
        logic       bad;
        int         diff;
        reset = 1'b0; rx_line = 1'b1; rx_ack = 1'b0;
        exp_data = 8'h00; exp_valid = 1'b0; exp_ferr = 0; exp_ovr = 0;
        repeat (3) @(negedge clk);
        check_eq("reset_data",  32'(rx_data), 32'h00);
        check_eq("reset_valid", 32'(rx_valid), 32'h0);
        check_eq("reset_busy",  32'(rx_busy), 32'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 1: basic frame and rx_valid latency
        send_frame(8'hA5, 1'b1, -1, -1);
        expect_good(8'hA5);
        diff = rise_cyc - c0;
        check_eq("t1_latency", 32'(diff >= 98 && diff <= 99), 32'h1);
        check_eq("t1_busy", 32'(rx_busy), 32'h0);
        check_model("t1");

        // 2: short glitch is rejected
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("t2_busy_early", 32'(rx_busy), 32'h0);
        repeat (192) @(negedge clk);
        check_model("t2");

        // 3: framing error, break, then recovery
        do_ack();
        send_frame(8'h00, 1'b0, -1, -1);
        exp_ferr++;
        check_eq("t3_busy_break", 32'(rx_busy), 32'h1);
        repeat (50) @(negedge clk);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        check_model("t3_bad");
        send_frame(8'h5A, 1'b1, -1, -1);
        expect_good(8'h5A);
        check_model("t3_good");

        // 4: back-to-back frames without ack give one overrun
        do_ack();
        send_frame(8'h3C, 1'b1, -1, -1);
        expect_good(8'h3C);
        send_frame(8'hC3, 1'b1, -1, -1);
        expect_good(8'hC3);
        check_model("t4");

        // 5: ack coincident with the next good-stop write
        do_ack();
        send_frame(8'h81, 1'b1, -1, -1);
        expect_good(8'h81);
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b1, 97, -1);
        exp_data = b;
        check_model("t5");

        // 6: reset mid-frame discards the partial byte
        send_frame(8'hFF, 1'b1, -1, 55);
        exp_data = 8'h00; exp_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t6_data_after_rst",  32'(rx_data), 32'h00);
        check_eq("t6_valid_after_rst", 32'(rx_valid), 32'h0);
        send_frame(8'h96, 1'b1, -1, -1);
        expect_good(8'h96);
        check_model("t6");

        // Randomised traffic: random bytes, gaps, acks and bad stop bits
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 1) == 1) do_ack();
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            send_frame(b, ~bad, -1, -1);
            if (bad) begin
                exp_ferr++;
                repeat ($urandom_range(0, 20)) @(negedge clk);
                rx_line = 1'b1;
                repeat ($urandom_range(5, 10)) @(negedge clk);
            end else begin
                expect_good(b);
                repeat ($urandom_range(0, 15)) @(negedge clk);
            end
            check_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
